// File: rtl/uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frontend
//  Purpose  : Oversampling UART receive front-end. Synchronises the rx pad,
//             qualifies start bits (glitch rejection), samples each bit at
//             mid-bit, checks framing (and even parity when compiled in) and
//             delivers clean bytes with a one-cycle valid strobe.
//  Ports    : clk_i          system clock
//             nrst_i         asynchronous active-low reset
//             rxd_i          raw serial line, idle high, asynchronous to clk_i
//             byte_valid_o   one-cycle strobe, byte_data_o holds a good byte
//             byte_data_o    last good byte received (LSB first on the line)
//             frame_err_o    one-cycle strobe, stop bit sampled low
//             parity_err_o   one-cycle strobe, parity mismatch (0 without macro)
//             err_count_o    saturating count of frame/parity error events
//             busy_o         high whenever the receiver is not idle
//  Macro    : UART_PARITY_EN - adds an even-parity bit between data and stop.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 16,   // clk cycles per serial bit, 4..4095
    parameter int SYNC_STAGES  = 2     // synchroniser depth on rxd_i, 2..3
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic [7:0] err_count_o,
    output logic       busy_o
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bitidx_q, bitidx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_data_q, byte_data_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   rxd_s;
    logic                   cnt_last;
    logic                   err_evt;
`ifdef UART_PARITY_EN
    logic                   par_bit_q, par_bit_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // ------------------------------------------------------------------
    // Synchroniser: flops reset to 1 so a reset never looks like a start
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
        end
    end

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign cnt_last = (cnt_q == C_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitidx_q     <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
`ifdef UART_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitidx_q     <= bitidx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
`ifdef UART_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitidx_d     = bitidx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = S_START;
                end
            end

            // Re-check the line half a bit later; a pulse shorter than
            // that is a glitch and is dropped silently.
            S_START: begin
                if (cnt_q == C_HALF_M1) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d  = S_DATA;
                        bitidx_d = '0;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            // cnt is now phase-aligned to mid-bit, so every full count
            // lands in the middle of the next bit.
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d    = '0;
                    shift_d  = {rxd_s, shift_q[7:1]};
                    bitidx_d = bitidx_q + 3'd1;
                    if (bitidx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    par_bit_d = rxd_s;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
`endif

            // Framing error outranks parity: a low stop bit means the
            // parity sample itself may be bogus.
            S_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
`ifdef UART_PARITY_EN
                    end else if (par_bit_q != (^shift_q)) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
`endif
                    end else begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end

            // A line held low (break) must go high before a new start.
            S_BREAK: begin
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef UART_PARITY_EN
    assign err_evt = frame_err_d | parity_err_d;
`else
    assign err_evt = frame_err_d;
`endif

    always_comb begin
        err_count_d = err_count_q;
        if (err_evt && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;
    assign err_count_o  = err_count_q;
    assign busy_o       = (state_q != S_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_frontend
//  Purpose  : Directed self-checking bench for uart_rx_frontend.
//  Macro    : UART_PARITY_EN - also exercises the parity frame format.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frontend;

    localparam int CPB = 16;
`ifdef UART_PARITY_EN
    localparam int LAT = CPB / 2 + 10 * CPB;
`else
    localparam int LAT = CPB / 2 + 9 * CPB;
`endif

    logic       clk;
    logic       nrst;
    logic       rxd;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       parity_err;
    logic [7:0] err_count;
    logic       busy;

    uart_rx_frontend #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i        (clk),
        .nrst_i       (nrst),
        .rxd_i        (rxd),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .err_count_o  (err_count),
        .busy_o       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the inactive edge
    int         vcount        = 0;
    int         fcount        = 0;
    int         pcount        = 0;
    int         v_cyc         = 0;
    int         busy_rise_cyc = 0;
    logic       busy_prev     = 1'b0;
    logic       chk_next      = 1'b0;
    logic       busy_after    = 1'b1;
    logic [7:0] vbytes[$];

    always @(negedge clk) begin
        if (byte_valid) begin
            vcount = vcount + 1;
            vbytes.push_back(byte_data);
            v_cyc    = cyc;
            chk_next = 1'b1;
        end else if (chk_next) begin
            busy_after = busy;
            chk_next   = 1'b0;
        end
        if (frame_err)  fcount = fcount + 1;
        if (parity_err) pcount = pcount + 1;
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy;
    end

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) npass = npass + 1;
        else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) rxd = 1'b1;
`endif
        send_bit(stop_b);
    endtask

    int v0;

    initial begin
        nrst = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid",  byte_valid, 0);
        chk("rst_data",   byte_data,  0);
        chk("rst_ferr",   frame_err,  0);
        chk("rst_perr",   parity_err, 0);
        chk("rst_errcnt", err_count,  0);
        chk("rst_busy",   busy,       0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        // Clean 0xA5 frame
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("a5_count",   vcount, 1);
        chk("a5_data",    byte_data, 8'hA5);
        chk("a5_latency", v_cyc - busy_rise_cyc, LAT);
        chk("a5_busy_after", busy_after, 0);
        chk("a5_errcnt",  err_count, 0);

        // 3-cycle glitch is rejected
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_count",  vcount, 1);
        chk("glitch_ferr",   fcount, 0);
        chk("glitch_errcnt", err_count, 0);
        chk("glitch_busy",   busy, 0);

        // 0x3C with low stop bit, then line held low
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        chk("brk_ferr",    fcount, 1);
        chk("brk_data",    byte_data, 8'hA5);
        chk("brk_errcnt",  err_count, 1);
        chk("brk_busy",    busy, 1);
        chk("brk_novalid", vcount, 1);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        chk("brk_idle",    busy, 0);
        chk("brk_nostart", vcount, 1);

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("b2b_count", vcount, 3);
        chk("b2b_first", vbytes[1], 8'h00);
        chk("b2b_second", vbytes[2], 8'hFF);
        chk("b2b_errcnt", err_count, 1);
        chk("b2b_ferr",   fcount, 1);

        // Reset during data bit 4 of 0x5A
        send_bit(1'b0);
        send_bit(1'b0);   // 0x5A bit0
        send_bit(1'b1);   // bit1
        send_bit(1'b0);   // bit2
        send_bit(1'b1);   // bit3
        rxd = 1'b1;       // bit4
        repeat (8) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("mrst_data",   byte_data, 0);
        chk("mrst_errcnt", err_count, 0);
        chk("mrst_busy",   busy, 0);
        chk("mrst_valid",  byte_valid, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_nostrobe", vcount, 3);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("post_count", vcount, 4);
        chk("post_data",  byte_data, 8'h81);
        chk("post_errcnt", err_count, 0);

`ifdef UART_PARITY_EN
        // Good parity then bad parity for 0x07
        v0 = vcount;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("par_good_count", vcount, v0 + 1);
        chk("par_good_data",  byte_data, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("par_bad_perr",   pcount, 1);
        chk("par_bad_count",  vcount, v0 + 1);
        chk("par_bad_errcnt", err_count, 1);
        chk("par_bad_data",   byte_data, 8'h07);
`else
        v0 = vcount;
        chk("nopar_perr", pcount, 0);
        chk("nopar_count", vcount, v0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
